// File: rtl/packet_injector_if.sv
// Injection-port bundle: packet request handshake, flit channel toward the
// router, credit return and status flags.
interface packet_injector_if #(
  parameter int num_vcs           = 4,
  parameter int buffer_size       = 8,
  parameter int max_payload_length = 4,
  parameter int flit_data_width   = 64,
  parameter int router_addr_width = 4
);
  localparam int vc_idx_width    = $clog2(num_vcs);
  localparam int len_width       = $clog2(max_payload_length + 1);
  localparam int flow_ctrl_width = 1 + vc_idx_width;
  localparam int channel_width   = 3 + vc_idx_width + flit_data_width;

  logic                         req_valid;
  logic                         req_ready;
  logic [vc_idx_width-1:0]      req_vc;
  logic [router_addr_width-1:0] req_dest;
  logic [len_width-1:0]         req_length;
  logic [flit_data_width-1:0]   req_data;
  logic [channel_width-1:0]     channel_out;
  logic [flow_ctrl_width-1:0]   flow_ctrl_in;
  logic                         busy;
  logic                         error;

  modport master (
    output req_valid, req_vc, req_dest, req_length, req_data, flow_ctrl_in,
    input  req_ready, channel_out, busy, error
  );

  modport slave (
    input  req_valid, req_vc, req_dest, req_length, req_data, flow_ctrl_in,
    output req_ready, channel_out, busy, error
  );
endinterface

// File: rtl/packet_injector.sv
// Credit-based packet injector: turns one request into a head flit plus up to
// max_payload_length body flits, stalling per VC whenever credits run out.
module packet_injector #(
  parameter int num_vcs            = 4,
  parameter int buffer_size        = 8,
  parameter int max_payload_length = 4,
  parameter int flit_data_width    = 64,
  parameter int router_addr_width  = 4
) (
  input logic clk,
  input logic reset,
  packet_injector_if.slave bus
);
  localparam int vc_idx_width  = $clog2(num_vcs);
  localparam int len_width     = $clog2(max_payload_length + 1);
  localparam int cred_width    = $clog2(buffer_size + 1);
  localparam int channel_width = 3 + vc_idx_width + flit_data_width;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state;
  logic                         ready_q;
  logic                         busy_q;
  logic                         error_q;
  logic [channel_width-1:0]     channel_q;
  logic [vc_idx_width-1:0]      cur_vc;
  logic [router_addr_width-1:0] cur_dest;
  logic [len_width-1:0]         cur_len;
  logic [flit_data_width-1:0]   cur_data;
  logic [len_width-1:0]         flit_idx;
  logic [cred_width-1:0]        credit [num_vcs];

  logic                         ret_valid;
  logic [vc_idx_width-1:0]      ret_vc;
  logic                         issue;
  logic                         is_head;
  logic                         is_tail;
  logic [flit_data_width-1:0]   flit_data;
  logic [num_vcs-1:0]           ret_hit;
  logic [num_vcs-1:0]           take_hit;

  assign {ret_valid, ret_vc} = bus.flow_ctrl_in;

  // Only the registered count gates issue, so a credit returned this cycle
  // cannot be spent until the next one.
  assign issue   = (state == SEND) && (credit[cur_vc] != '0);
  assign is_head = (flit_idx == '0);
  assign is_tail = (flit_idx == cur_len);

  always_comb begin
    flit_data = '0;
    if (is_head)
      flit_data[router_addr_width-1:0] = cur_dest;
    else
      flit_data = cur_data + flit_data_width'(flit_idx - len_width'(1));
  end

  always_comb begin
    ret_hit  = '0;
    take_hit = '0;
    for (int v = 0; v < num_vcs; v++) begin
      ret_hit[v]  = ret_valid && (ret_vc == vc_idx_width'(v));
      take_hit[v] = issue && (cur_vc == vc_idx_width'(v));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      channel_q <= '0;
      cur_vc    <= '0;
      cur_dest  <= '0;
      cur_len   <= '0;
      cur_data  <= '0;
      flit_idx  <= '0;
    end else begin
      channel_q <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_vc   <= bus.req_vc;
            cur_dest <= bus.req_dest;
            cur_len  <= bus.req_length;
            cur_data <= bus.req_data;
            flit_idx <= '0;
            state    <= SEND;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        SEND: begin
          if (issue) begin
            channel_q <= {1'b1, cur_vc, is_head, is_tail, flit_data};
            flit_idx  <= flit_idx + len_width'(1);
            if (is_tail) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A return and a spend on the same VC cancel; a return into a full counter
  // is dropped and latched as an overflow error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
      for (int v = 0; v < num_vcs; v++)
        credit[v] <= cred_width'(buffer_size);
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        if (ret_hit[v] && !take_hit[v]) begin
          if (credit[v] == cred_width'(buffer_size))
            error_q <= 1'b1;
          else
            credit[v] <= credit[v] + cred_width'(1);
        end else if (take_hit[v] && !ret_hit[v]) begin
          credit[v] <= credit[v] - cred_width'(1);
        end
      end
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;
  assign bus.channel_out = channel_q;
endmodule
